fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Fetch sequencer that drives the dual-port instruction memory (imem) in the rv32 OoO core. It holds the PC and presents addr1 = PC and addr2 = PC+4 each cycle, so two instructions are fetched per cycle. Each fetched pair is captured into a small in-order fetch queue, and the queue feeds decode through a valid/ready handshake. It also handles redirects from branch resolution and flags misaligned redirect targets.

Parameters:
IMEM_WORDSIZE, 32, instruction width in bits (matches imem).
RESET_PC, 32'h0000_0000, PC value loaded at reset.
FQ_DEPTH, 4, fetch queue depth in entries (one entry = one instruction pair); must be a power of 2 and at least 2.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
fetch_en  in  1  allow fetching
imem_addr1  out  32  byte address of lane 0, wired to imem addr1
imem_addr2  out  32  byte address of lane 1, wired to imem addr2
imem_instr1  in  IMEM_WORDSIZE  imem read data for addr1 (combinational, same cycle)
imem_instr2  in  IMEM_WORDSIZE  imem read data for addr2 (combinational, same cycle)
redirect_valid  in  1  branch/jump redirect request
redirect_pc  in  32  redirect target
out_valid  out  1  queue head is valid
out_ready  in  1  decode accepts the head
out_pc  out  32  PC of lane 0 of the head entry
out_instr1  out  IMEM_WORDSIZE  head lane-0 instruction
out_instr2  out  IMEM_WORDSIZE  head lane-1 instruction
fq_count  out  $clog2(FQ_DEPTH)+1  current queue occupancy
fault  out  1  misaligned redirect fault is active

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values:
  - pc = RESET_PC, so imem_addr1 = RESET_PC and imem_addr2 = RESET_PC+4.
  - state = IDLE.
  - fq_count = 0, out_valid = 0, fault = 0.
  - Queue storage is cleared, so out_pc, out_instr1 and out_instr2 read 0.
- Address generation: imem_addr1 = pc and imem_addr2 = pc + 4 are combinational from the pc register. Addition is modulo 2^32.
- State machine (IDLE, RUN, FAULT):
  - IDLE -> RUN when fetch_en = 1.
  - RUN -> IDLE when fetch_en = 0. The queue keeps draining while in IDLE.
  - From any state -> FAULT on redirect_valid with redirect_pc[1:0] != 0. In this case pc is not updated and the queue is flushed.
  - FAULT -> RUN on redirect_valid with an aligned target when fetch_en = 1; FAULT -> IDLE on the same redirect when fetch_en = 0. pc is loaded with the target in both cases.
  - fault = 1 exactly while state = FAULT.
- Push:
  - Condition: state = RUN, no redirect this cycle, and fq_count < FQ_DEPTH.
  - Action: enqueue {pc, imem_instr1, imem_instr2} and set pc <= pc + 8.
  - When the queue is full, pc holds and no push occurs. There is no same-cycle bypass when full: a pop in the same cycle does not enable a push.
- Pop: when out_valid && out_ready, the head is dequeued at the clock edge. out_valid = (fq_count != 0).
- Latency: a pair fetched at cycle N appears at the queue head at cycle N+1 if the queue was empty. There is no combinational path from the imem inputs to the out_* ports.
- Simultaneous push and pop: fq_count is unchanged, and entries leave in order.
- Redirect (aligned):
  - Takes priority over push and pop.
  - Next cycle: fq_count = 0, out_valid = 0, pc = redirect_pc.
  - The first new entry appears one cycle after that.
  - A pop offered in the redirect cycle is dropped along with the rest of the queue.
- PC wrap: pc = 32'hFFFF_FFF8 gives imem_addr2 = 32'hFFFF_FFFC, and the next pc is 0.
- Reset mid-operation: all state, the queue and pc return to their reset values immediately, without waiting for a clock edge.

Decomposition:
- fetch_pkg holds:
  - fetch_entry_t struct {pc, instr1, instr2}
  - fetch_state_e enum {IDLE, RUN, FAULT}
  - localparam INSTR_BYTES = 4
  - localparam FETCH_STRIDE = 8
- One sub-module, fetch_queue: a synchronous circular FIFO of fetch_entry_t.
  - Inputs: push, pop, flush.
  - Outputs: count, head.
  - Uses the same async active-low reset.
- fetch_ctrl contains the pc register, the state machine and the push/redirect control.

Test Plan:
1. imem model with mem[i] = 32'h1000 + i. Release reset, fetch_en = 1, out_ready = 1 → cycle 1: out_pc = 0, instr1 = 0x1000, instr2 = 0x1001. Cycle 2: out_pc = 8, instrs 0x1002 and 0x1003. fq_count stays 1.
2. Hold out_ready = 0 → fq_count reaches 4 after 4 cycles and imem_addr1 holds at 0x20. Then set out_ready = 1 → pops return out_pc 0, 8, 0x10, 0x18 in order, and pushes resume.
3. With fq_count = 3, redirect to 0x40 with out_ready = 1 → next cycle fq_count = 0, out_valid = 0, imem_addr1 = 0x40. The following cycle shows out_pc = 0x40.
4. Redirect to 0x42 → fault = 1, no pushes, pc unchanged. Then redirect to 0x10 → fault = 0 and the next entry has out_pc = 0x10.
5. Redirect to 0xFFFF_FFF8 → imem_addr1 = 0xFFFF_FFF8, imem_addr2 = 0xFFFF_FFFC, and the next pc is 0.
6. Assert rst_n = 0 mid-clock-phase while fq_count = 2 → fq_count = 0, out_valid = 0 and imem_addr1 = RESET_PC before the next clock edge. Pulsing fetch_en low puts the block in IDLE and holds pc constant.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch front end.
package fetch_pkg;

  localparam int INSTR_BYTES  = 4;
  localparam int FETCH_STRIDE = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr1;
    logic [31:0] instr2;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order circular FIFO of fetched instruction pairs. Flush dominates push/pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  entry_t                   push_data,
  output logic [$clog2(DEPTH):0]   count,
  output entry_t                   head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push;
  logic            do_pop;

  // Push is refused when full even if a pop happens in the same cycle.
  assign do_push = push && (count_q != FULL_CNT);
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC register, IDLE/RUN/FAULT control and the fetch queue feeding decode.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          IMEM_WORDSIZE = 32,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FQ_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_en,
  output logic [31:0]                imem_addr1,
  output logic [31:0]                imem_addr2,
  input  logic [IMEM_WORDSIZE-1:0]   imem_instr1,
  input  logic [IMEM_WORDSIZE-1:0]   imem_instr2,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [IMEM_WORDSIZE-1:0]   out_instr1,
  output logic [IMEM_WORDSIZE-1:0]   out_instr2,
  output logic [$clog2(FQ_DEPTH):0]  fq_count,
  output logic                       fault
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FQ_DEPTH);

  // Same layout as fetch_entry_t, but sized to the configured instruction width.
  typedef struct packed {
    logic [31:0]              pc;
    logic [IMEM_WORDSIZE-1:0] instr1;
    logic [IMEM_WORDSIZE-1:0] instr2;
  } entry_t;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         fault_q;
  logic         push;
  logic         pop;
  logic         flush;
  logic         fq_full;
  entry_t       push_data;
  entry_t       head;

  assign imem_addr1 = pc_q;
  assign imem_addr2 = pc_q + 32'(INSTR_BYTES);

  assign fq_full   = (fq_count == FULL_CNT);
  assign push_data = '{pc: pc_q, instr1: imem_instr1, instr2: imem_instr2};
  assign pop       = out_valid && out_ready && !redirect_valid;

  // Any redirect flushes; a misaligned one also parks the sequencer in FAULT without touching pc.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      flush = 1'b1;
      if (redirect_pc[1:0] != 2'b00) begin
        state_d = FAULT;
      end else begin
        pc_d    = redirect_pc;
        state_d = fetch_en ? RUN : IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_en) state_d = RUN;
        end
        RUN: begin
          if (!fq_full) begin
            push = 1'b1;
            pc_d = pc_q + 32'(FETCH_STRIDE);
          end
          if (!fetch_en) state_d = IDLE;
        end
        FAULT: state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= (state_d == FAULT);
    end
  end

  fetch_queue #(
    .DEPTH   (FQ_DEPTH),
    .entry_t (entry_t)
  ) u_fetch_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (push_data),
    .count     (fq_count),
    .head      (head)
  );

  assign out_valid  = (fq_count != '0);
  assign out_pc     = head.pc;
  assign out_instr1 = head.instr1;
  assign out_instr2 = head.instr2;
  assign fault      = fault_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a combinational imem holding mem[i] = 0x1000 + i.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] imem_addr1;
  logic [31:0] imem_addr2;
  logic [31:0] imem_instr1;
  logic [31:0] imem_instr2;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr1;
  logic [31:0] out_instr2;
  logic [2:0]  fq_count;
  logic        fault;

  int checks;
  int errors;

  fetch_ctrl #(
    .IMEM_WORDSIZE (32),
    .RESET_PC      (32'h0000_0000),
    .FQ_DEPTH      (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr1     (imem_addr1),
    .imem_addr2     (imem_addr2),
    .imem_instr1    (imem_instr1),
    .imem_instr2    (imem_instr2),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr1     (out_instr1),
    .out_instr2     (out_instr2),
    .fq_count       (fq_count),
    .fault          (fault)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // imem model: word index = byte address / 4
  assign imem_instr1 = 32'h1000 + (imem_addr1 >> 2);
  assign imem_instr2 = 32'h1000 + (imem_addr2 >> 2);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then sample/drive 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #12;

    // Reset state
    chk("rst_addr1", imem_addr1, 32'h0);
    chk("rst_addr2", imem_addr2, 32'h4);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_count", 32'(fq_count), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_instr1", out_instr1, 32'h0);

    // 1. Streaming with decode always ready
    step();
    rst_n     = 1'b1;
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    step();
    chk("t1_idle_to_run_count", 32'(fq_count), 32'h0);
    step();
    chk("t1_pc0", out_pc, 32'h0);
    chk("t1_pc0_i1", out_instr1, 32'h1000);
    chk("t1_pc0_i2", out_instr2, 32'h1001);
    chk("t1_count_a", 32'(fq_count), 32'h1);
    step();
    chk("t1_pc8", out_pc, 32'h8);
    chk("t1_pc8_i1", out_instr1, 32'h1002);
    chk("t1_pc8_i2", out_instr2, 32'h1003);
    chk("t1_count_b", 32'(fq_count), 32'h1);

    // 2. Backpressure fills the queue, then it drains in order
    fetch_en  = 1'b1;
    out_ready = 1'b0;
    do_reset();
    step();
    step();
    step();
    step();
    step();
    chk("t2_full_count", 32'(fq_count), 32'h4);
    chk("t2_full_addr", imem_addr1, 32'h20);
    step();
    chk("t2_hold_count", 32'(fq_count), 32'h4);
    chk("t2_hold_addr", imem_addr1, 32'h20);
    chk("t2_head0", out_pc, 32'h0);
    out_ready = 1'b1;
    step();
    chk("t2_no_bypass_count", 32'(fq_count), 32'h3);
    chk("t2_no_bypass_addr", imem_addr1, 32'h20);
    chk("t2_head8", out_pc, 32'h8);
    step();
    chk("t2_head10", out_pc, 32'h10);
    chk("t2_resume_addr", imem_addr1, 32'h28);
    chk("t2_pushpop_count", 32'(fq_count), 32'h3);
    step();
    chk("t2_head18", out_pc, 32'h18);

    // 3. Aligned redirect flushes the queue
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk("t3_count", 32'(fq_count), 32'h0);
    chk("t3_valid", 32'(out_valid), 32'h0);
    chk("t3_addr1", imem_addr1, 32'h40);
    step();
    chk("t3_out_pc", out_pc, 32'h40);
    chk("t3_out_i1", out_instr1, 32'h1010);
    chk("t3_count_after", 32'(fq_count), 32'h1);

    // 4. Misaligned redirect faults, aligned one recovers
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    step();
    redirect_valid = 1'b0;
    chk("t4_fault", 32'(fault), 32'h1);
    chk("t4_count", 32'(fq_count), 32'h0);
    chk("t4_addr1", imem_addr1, 32'h48);
    step();
    chk("t4_fault_hold", 32'(fault), 32'h1);
    chk("t4_no_push", 32'(fq_count), 32'h0);
    chk("t4_pc_hold", imem_addr1, 32'h48);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    step();
    redirect_valid = 1'b0;
    chk("t4_clear", 32'(fault), 32'h0);
    chk("t4_new_addr", imem_addr1, 32'h10);
    step();
    chk("t4_out_pc", out_pc, 32'h10);
    chk("t4_valid", 32'(out_valid), 32'h1);

    // 5. PC wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    chk("t5_addr1", imem_addr1, 32'hFFFF_FFF8);
    chk("t5_addr2", imem_addr2, 32'hFFFF_FFFC);
    step();
    chk("t5_wrap", imem_addr1, 32'h0);
    chk("t5_out_pc", out_pc, 32'hFFFF_FFF8);
    chk("t5_out_i1", out_instr1, 32'h4000_0FFE);
    chk("t5_out_i2", out_instr2, 32'h4000_0FFF);

    // 6. Asynchronous reset mid-phase, then fetch_en pulse to IDLE
    out_ready = 1'b0;
    step();
    chk("t6_pre_count", 32'(fq_count), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_count", 32'(fq_count), 32'h0);
    chk("t6_async_valid", 32'(out_valid), 32'h0);
    chk("t6_async_addr", imem_addr1, 32'h0);
    chk("t6_async_out_pc", out_pc, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    chk("t6_run_count", 32'(fq_count), 32'h2);
    chk("t6_run_addr", imem_addr1, 32'h10);
    fetch_en  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("t6_last_push_addr", imem_addr1, 32'h18);
    chk("t6_last_push_count", 32'(fq_count), 32'h2);
    step();
    chk("t6_idle_addr_a", imem_addr1, 32'h18);
    chk("t6_drain_a", 32'(fq_count), 32'h1);
    step();
    chk("t6_idle_addr_b", imem_addr1, 32'h18);
    chk("t6_drain_b", 32'(fq_count), 32'h0);
    chk("t6_fault", 32'(fault), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
